// File: rtl/dram_resp_pkg.sv
// Shared constants, slot operation type and slot decode for the DRAM responder.
package dram_resp_pkg;

    localparam int SLOT_LEN     = 4;
    localparam int RRDY_LAT     = 2;
    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_REFR_PER = 64;
    localparam int DATA_W       = 16;
    localparam int BUS_ADDR_W   = 21;
    localparam int PHASE_W      = $clog2(SLOT_LEN);
    localparam int CNT_W        = 10;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE,
        OP_REFRESH
    } dram_op_e;

    // Requests always win the slot; refresh only takes a slot nobody asked for.
    function automatic dram_op_e decode_op(input logic req, input logic rnw, input logic rfsh_pend);
        if (req) return rnw ? OP_READ : OP_WRITE;
        return rfsh_pend ? OP_REFRESH : OP_IDLE;
    endfunction

endpackage

// File: rtl/dram_resp_mem.sv
// Byte-lane writable word store with a registered (synchronous) read port.
module dram_resp_mem
    import dram_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: storage has no reset on purpose; contents must survive rst and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
        if (re)    rdata           <= mem[addr];
    end

endmodule

// File: rtl/dram_resp.sv
// Slot-based DRAM responder: 4-clock slots, one read/write/refresh per slot, deferred refresh.
module dram_resp
    import dram_resp_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int REFR_PER = DEF_REFR_PER
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dram_req,
    input  logic                  dram_rnw,
    input  logic [BUS_ADDR_W-1:0] dram_addr,
    input  logic [1:0]            dram_bsel,
    input  logic [DATA_W-1:0]     dram_wrdata,
    output logic                  dram_cbeg,
    output logic                  dram_rrdy,
    output logic [DATA_W-1:0]     dram_rddata,
    output logic                  rfsh
);

    localparam int RD_STAGES = RRDY_LAT - 1;

    logic [PHASE_W-1:0]   phase;
    logic [CNT_W-1:0]     slot_cnt;
    logic                 rfsh_pend;
    logic [RD_STAGES-1:0] rd_pipe;
    dram_op_e             op;
    logic [1:0]           mem_we;
    logic                 mem_re;
    logic [DATA_W-1:0]    mem_q;
    logic                 unused_addr_hi;

    assign unused_addr_hi = ^dram_addr[BUS_ADDR_W-1:ADDR_W];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        op = OP_IDLE;
        if (dram_cbeg) op = decode_op(dram_req, dram_rnw, rfsh_pend);
    end

    // A zero byte-select write decodes as a write with no lanes enabled, i.e. nothing happens.
    assign mem_we = (op == OP_WRITE) ? dram_bsel : 2'b00;
    assign mem_re = (op == OP_READ);

    dram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (dram_addr[ADDR_W-1:0]),
        .wdata (dram_wrdata),
        .re    (mem_re),
        .rdata (mem_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            dram_cbeg   <= 1'b0;
            slot_cnt    <= '0;
            rfsh_pend   <= 1'b0;
            rd_pipe     <= '0;
            dram_rrdy   <= 1'b0;
            dram_rddata <= '0;
            rfsh        <= 1'b0;
        end else begin
            phase     <= phase + 1'b1;
            dram_cbeg <= (phase == PHASE_W'(SLOT_LEN - 2));

            // The memory read port holds its word until the next read, at most one per slot.
            rd_pipe   <= RD_STAGES'({rd_pipe, mem_re});
            dram_rrdy <= rd_pipe[RD_STAGES-1];
            if (rd_pipe[RD_STAGES-1]) dram_rddata <= mem_q;

            rfsh <= (op == OP_REFRESH);
            if (op == OP_REFRESH) rfsh_pend <= 1'b0;

            // A wrap in the same slot overrides the clear above, so pending saturates and never gets lost.
            if (dram_cbeg) begin
                if (slot_cnt == CNT_W'(REFR_PER - 1)) begin
                    slot_cnt  <= '0;
                    rfsh_pend <= 1'b1;
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_resp.sv
// Directed bench for dram_resp: slot cadence, table of accesses, refresh deferral, reset mid-read.
module tb_dram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dram_req = 1'b0;
    logic        dram_rnw = 1'b1;
    logic [20:0] dram_addr = '0;
    logic [1:0]  dram_bsel = '0;
    logic [15:0] dram_wrdata = '0;
    logic        dram_cbeg;
    logic        dram_rrdy;
    logic [15:0] dram_rddata;
    logic        rfsh;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        req;
        logic        rnw;
        logic [20:0] addr;
        logic [1:0]  bsel;
        logic [15:0] wdata;
        logic        exp_rrdy;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    dram_resp #(.ADDR_W(12), .REFR_PER(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .dram_req    (dram_req),
        .dram_rnw    (dram_rnw),
        .dram_addr   (dram_addr),
        .dram_bsel   (dram_bsel),
        .dram_wrdata (dram_wrdata),
        .dram_cbeg   (dram_cbeg),
        .dram_rrdy   (dram_rrdy),
        .dram_rddata (dram_rddata),
        .rfsh        (rfsh)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Leaves the bench at the negedge of the cycle in which rst was released (cycle 1).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        dram_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {dram_cbeg, dram_rrdy, dram_rddata, rfsh}, 32'h0);
        rst = 1'b0;
    endtask

    task automatic wait_cbeg();
        int k = 0;
        while (!dram_cbeg && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("cbeg_seen", dram_cbeg, 1'b1);
    endtask

    // Drives one slot at N, puts conflicting junk on the bus in N+1..N+3, returns at N+4.
    task automatic run_slot(input logic req, input logic rnw, input logic [20:0] addr,
                            input logic [1:0] bsel, input logic [15:0] wdata,
                            output logic [2:0] rrdy_seq, output logic [15:0] data_n2,
                            output logic rfsh_n1, output logic rfsh_other);
        wait_cbeg();
        dram_req = req; dram_rnw = rnw; dram_addr = addr; dram_bsel = bsel; dram_wrdata = wdata;
        @(negedge clk);
        rrdy_seq[2] = dram_rrdy;
        rfsh_n1 = rfsh;
        dram_req = 1'b1; dram_rnw = 1'b0; dram_addr = 21'h005; dram_bsel = 2'b11; dram_wrdata = 16'hDEAD;
        @(negedge clk);
        rrdy_seq[1] = dram_rrdy;
        data_n2 = dram_rddata;
        rfsh_other = rfsh;
        @(negedge clk);
        rrdy_seq[0] = dram_rrdy;
        rfsh_other = rfsh_other | rfsh;
        dram_req = 1'b0; dram_rnw = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]  seq;
        logic [15:0] data;
        logic        rf1, rfo;

        vecs[0]  = '{1'b1, 1'b0, 21'h000005, 2'b11, 16'h1234, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 21'h000005, 2'b00, 16'h0000, 1'b1, 16'h1234};
        vecs[2]  = '{1'b1, 1'b0, 21'h000005, 2'b10, 16'hABCD, 1'b0, 16'h1234};
        vecs[3]  = '{1'b1, 1'b1, 21'h001005, 2'b00, 16'h0000, 1'b1, 16'hAB34};
        vecs[4]  = '{1'b1, 1'b0, 21'h000006, 2'b11, 16'h55AA, 1'b0, 16'hAB34};
        vecs[5]  = '{1'b1, 1'b0, 21'h000006, 2'b01, 16'h0077, 1'b0, 16'hAB34};
        vecs[6]  = '{1'b1, 1'b1, 21'h000006, 2'b00, 16'h0000, 1'b1, 16'h5577};
        vecs[7]  = '{1'b1, 1'b0, 21'h000006, 2'b00, 16'hFFFF, 1'b0, 16'h5577};
        vecs[8]  = '{1'b1, 1'b1, 21'h000006, 2'b00, 16'h0000, 1'b1, 16'h5577};
        vecs[9]  = '{1'b1, 1'b0, 21'h000FFF, 2'b11, 16'hBEEF, 1'b0, 16'h5577};
        vecs[10] = '{1'b1, 1'b1, 21'h1FFFFF, 2'b00, 16'h0000, 1'b1, 16'hBEEF};
        vecs[11] = '{1'b1, 1'b1, 21'h000005, 2'b00, 16'h0000, 1'b1, 16'hAB34};
        vecs[12] = '{1'b0, 1'b1, 21'h000005, 2'b00, 16'h0000, 1'b0, 16'hAB34};

        // Idle cadence: cbeg on cycles 4,8,..; with REFR_PER=4 the wrap lands on slot 4,
        // so refresh pulses follow slots 5,9,13,... at cycle 4k+1.
        do_reset();
        for (int cyc = 1; cyc <= 100; cyc++) begin
            logic exp_cb, exp_rf;
            if (cyc > 1) @(negedge clk);
            exp_cb = (cyc % 4 == 0);
            exp_rf = (cyc >= 21) && ((cyc - 21) % 16 == 0);
            check($sformatf("cadence_c%0d", cyc), {dram_cbeg, dram_rrdy, rfsh}, {exp_cb, 1'b0, exp_rf});
        end

        foreach (vecs[i]) begin
            run_slot(vecs[i].req, vecs[i].rnw, vecs[i].addr, vecs[i].bsel, vecs[i].wdata,
                     seq, data, rf1, rfo);
            check($sformatf("vec%0d_rrdy", i), seq, {1'b0, vecs[i].exp_rrdy, 1'b0});
            check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
        end

        // Back-to-back reads for 10 slots: two wraps happen, no refresh may steal a slot.
        do_reset();
        for (int s = 1; s <= 10; s++) begin
            run_slot(1'b1, 1'b1, 21'h000005, 2'b00, 16'h0000, seq, data, rf1, rfo);
            check($sformatf("defer%0d_rrdy", s), seq, 3'b010);
            check($sformatf("defer%0d_data", s), data, 16'hAB34);
            check($sformatf("defer%0d_rfsh", s), {rf1, rfo}, 2'b00);
        end
        run_slot(1'b0, 1'b1, 21'h0, 2'b00, 16'h0, seq, data, rf1, rfo);
        check("defer_first_idle_rfsh", {rf1, rfo}, 2'b10);
        run_slot(1'b0, 1'b1, 21'h0, 2'b00, 16'h0, seq, data, rf1, rfo);
        check("defer_saturate_no_second", {rf1, rfo}, 2'b00);
        run_slot(1'b0, 1'b1, 21'h0, 2'b00, 16'h0, seq, data, rf1, rfo);
        check("wrap_idle_then_rfsh", {rf1, rfo}, 2'b10);

        // Reset between read sample and rrdy cancels the read; stored data survives.
        run_slot(1'b1, 1'b0, 21'h00000A, 2'b11, 16'h5A5A, seq, data, rf1, rfo);
        run_slot(1'b1, 1'b1, 21'h000005, 2'b00, 16'h0000, seq, data, rf1, rfo);
        check("pre_reset_data", data, 16'hAB34);
        wait_cbeg();
        dram_req = 1'b1; dram_rnw = 1'b1; dram_addr = 21'h00000A;
        @(negedge clk);
        rst = 1'b1;
        dram_req = 1'b0;
        @(negedge clk);
        check("midread_cancel", {dram_rrdy, dram_rddata, rfsh}, 18'h0);
        @(negedge clk);
        check("midread_hold", {dram_cbeg, dram_rrdy, dram_rddata}, 18'h0);
        rst = 1'b0;
        run_slot(1'b1, 1'b1, 21'h00000A, 2'b00, 16'h0000, seq, data, rf1, rfo);
        check("after_reset_rrdy", seq, 3'b010);
        check("after_reset_data", data, 16'h5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
